// File: rtl/branch_redirect_ctrl_if.sv
// Bundle between the EX-stage branch decision, fetch and the redirect sequencer.
// master = pipeline/EX side driving decisions, slave = the sequencer.
interface branch_redirect_ctrl_if;
  logic        ex_valid;
  logic        ex_is_cond_branch;
  logic [1:0]  decision;
  logic [31:0] pcrel_target;
  logic [31:0] reg_target;
  logic        fetch_ready;
  logic        ctr_clr;
  logic        pc_load;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        stall_override;
  logic        misalign_err;
  logic [15:0] cnt_cond;
  logic [15:0] cnt_taken;
  logic [15:0] cnt_jalr;
  logic [15:0] cnt_hold;

  modport master (
    output ex_valid, ex_is_cond_branch, decision, pcrel_target, reg_target,
           fetch_ready, ctr_clr,
    input  pc_load, redirect_pc, flush_if_id, flush_id_ex, flush_ex_mem,
           stall_override, misalign_err, cnt_cond, cnt_taken, cnt_jalr, cnt_hold
  );

  modport slave (
    input  ex_valid, ex_is_cond_branch, decision, pcrel_target, reg_target,
           fetch_ready, ctr_clr,
    output pc_load, redirect_pc, flush_if_id, flush_id_ex, flush_ex_mem,
           stall_override, misalign_err, cnt_cond, cnt_taken, cnt_jalr, cnt_hold
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer: registered PC redirect, 3-stage squash,
// fetch-hold while imem is busy, and saturating control-flow counters.
module brc_sat_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = 16'h0000;
    else if (inc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 16'h0000;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module branch_redirect_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_redirect_ctrl_if.slave  bus
);
  localparam int NUM_CTR = 4;
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

  localparam logic [1:0] DEC_PCREL = 2'b01;
  localparam logic [1:0] DEC_REG   = 2'b10;

  logic [0:0]  state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        misalign_q, misalign_d;

  logic        in_run, in_redir, accept;
  logic [31:0] sel_tgt;
  logic [NUM_CTR-1:0]       ctr_inc;
  logic [NUM_CTR-1:0][15:0] ctr_val;

  assign in_run   = (state_q == RUN);
  assign in_redir = (state_q == REDIRECT);
  // Decision 11 falls out as "no redirect" because only 01/10 accept.
  assign accept   = in_run && bus.ex_valid &&
                    (bus.decision == DEC_PCREL || bus.decision == DEC_REG);

  always_comb begin
    sel_tgt = bus.pcrel_target;
    if (bus.decision == DEC_REG) sel_tgt = {bus.reg_target[31:1], 1'b0};
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    misalign_d    = misalign_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          state_d       = REDIRECT;
          redirect_pc_d = {sel_tgt[31:2], 2'b00};
          if (sel_tgt[1]) misalign_d = 1'b1;
        end
      end
      default: begin
        if (bus.fetch_ready) state_d = RUN;
      end
    endcase
    if (bus.ctr_clr) misalign_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      redirect_pc_q <= 32'h0000_0000;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  // Counter order: cond, taken, jalr, hold.
  assign ctr_inc[0] = in_run && bus.ex_valid && bus.ex_is_cond_branch;
  assign ctr_inc[1] = accept;
  assign ctr_inc[2] = accept && (bus.decision == DEC_REG);
  assign ctr_inc[3] = in_redir && !bus.fetch_ready;

  generate
    for (genvar g = 0; g < NUM_CTR; g++) begin : g_ctr
      brc_sat_ctr u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.ctr_clr),
        .inc   (ctr_inc[g]),
        .cnt   (ctr_val[g])
      );
    end
  endgenerate

  assign bus.pc_load        = in_redir;
  assign bus.flush_if_id    = in_redir;
  assign bus.flush_id_ex    = in_redir;
  assign bus.flush_ex_mem   = in_redir;
  assign bus.stall_override = in_redir;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.misalign_err   = misalign_q;
  assign bus.cnt_cond       = ctr_val[0];
  assign bus.cnt_taken      = ctr_val[1];
  assign bus.cnt_jalr       = ctr_val[2];
  assign bus.cnt_hold       = ctr_val[3];
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with hand-computed expectations.
module tb_branch_redirect_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_redirect_ctrl_if bus ();

  branch_redirect_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic exp);
    chk({tag, "_pc_load"}, {31'd0, bus.pc_load}, {31'd0, exp});
    chk({tag, "_flush"}, {29'd0, bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem},
        {29'd0, {3{exp}}});
    chk({tag, "_stall_ovr"}, {31'd0, bus.stall_override}, {31'd0, exp});
  endtask

  task automatic drive(input logic v, input logic c, input logic [1:0] d,
                       input logic [31:0] pcrel, input logic [31:0] rt);
    bus.ex_valid          = v;
    bus.ex_is_cond_branch = c;
    bus.decision          = d;
    bus.pcrel_target      = pcrel;
    bus.reg_target        = rt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.fetch_ready = 1'b1;
    bus.ctr_clr     = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 32'h40, 32'h0);

    // Reset held with a live decision
    tick(); tick();
    chk_ctl("rst", 1'b0);
    chk("rst_pc", bus.redirect_pc, 32'h0);
    chk("rst_mis", {31'd0, bus.misalign_err}, 32'd0);
    chk("rst_taken", {16'd0, bus.cnt_taken}, 32'd0);
    chk("rst_cond", {16'd0, bus.cnt_cond}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_ctl("rst_rel", 1'b1);
    chk("rst_rel_pc", bus.redirect_pc, 32'h40);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk_ctl("rst_rel_exit", 1'b0);
    bus.ctr_clr = 1'b1;
    tick();
    bus.ctr_clr = 1'b0;
    chk("clr0_taken", {16'd0, bus.cnt_taken}, 32'd0);

    // Taken conditional branch
    drive(1'b1, 1'b1, 2'b01, 32'h100, 32'h0);
    tick();
    chk_ctl("tkn", 1'b1);
    chk("tkn_pc", bus.redirect_pc, 32'h100);
    chk("tkn_cond", {16'd0, bus.cnt_cond}, 32'd1);
    chk("tkn_taken", {16'd0, bus.cnt_taken}, 32'd1);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk_ctl("tkn_exit", 1'b0);
    chk("tkn_pc_ret", bus.redirect_pc, 32'h100);

    // JALR with bit 1 set in target
    drive(1'b1, 1'b0, 2'b10, 32'h0, 32'h207);
    tick();
    chk_ctl("jalr", 1'b1);
    chk("jalr_pc", bus.redirect_pc, 32'h204);
    chk("jalr_mis", {31'd0, bus.misalign_err}, 32'd1);
    chk("jalr_cnt", {16'd0, bus.cnt_jalr}, 32'd1);
    chk("jalr_taken", {16'd0, bus.cnt_taken}, 32'd2);
    chk("jalr_cond", {16'd0, bus.cnt_cond}, 32'd1);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    bus.ctr_clr = 1'b1;
    tick();
    bus.ctr_clr = 1'b0;
    chk("clr_mis", {31'd0, bus.misalign_err}, 32'd0);
    chk("clr_taken", {16'd0, bus.cnt_taken}, 32'd0);
    chk("clr_jalr", {16'd0, bus.cnt_jalr}, 32'd0);
    chk("clr_cond", {16'd0, bus.cnt_cond}, 32'd0);
    chk("clr_pc_kept", bus.redirect_pc, 32'h204);

    // Clear wins over same-cycle increment and misalign set
    drive(1'b1, 1'b0, 2'b01, 32'h302, 32'h0);
    bus.ctr_clr = 1'b1;
    tick();
    bus.ctr_clr = 1'b0;
    chk_ctl("clrpri", 1'b1);
    chk("clrpri_pc", bus.redirect_pc, 32'h300);
    chk("clrpri_mis", {31'd0, bus.misalign_err}, 32'd0);
    chk("clrpri_taken", {16'd0, bus.cnt_taken}, 32'd0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();

    // Fetch hold for 3 cycles with a wrong-path decision presented
    drive(1'b1, 1'b0, 2'b01, 32'h400, 32'h0);
    bus.fetch_ready = 1'b0;
    tick();
    chk_ctl("hold1", 1'b1);
    chk("hold1_cnt", {16'd0, bus.cnt_hold}, 32'd0);
    drive(1'b1, 1'b1, 2'b01, 32'h500, 32'h0);
    tick();
    chk("hold2_cnt", {16'd0, bus.cnt_hold}, 32'd1);
    tick();
    chk("hold3_cnt", {16'd0, bus.cnt_hold}, 32'd2);
    tick();
    chk_ctl("hold4", 1'b1);
    chk("hold4_cnt", {16'd0, bus.cnt_hold}, 32'd3);
    chk("hold4_pc", bus.redirect_pc, 32'h400);
    bus.fetch_ready = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk_ctl("hold_exit", 1'b0);
    chk("hold_exit_cnt", {16'd0, bus.cnt_hold}, 32'd3);
    chk("hold_exit_pc", bus.redirect_pc, 32'h400);
    chk("hold_taken", {16'd0, bus.cnt_taken}, 32'd1);
    chk("hold_cond", {16'd0, bus.cnt_cond}, 32'd0);

    // Back-to-back redirects
    drive(1'b1, 1'b0, 2'b01, 32'h600, 32'h0);
    tick();
    chk("b2b1_pc", bus.redirect_pc, 32'h600);
    drive(1'b1, 1'b0, 2'b01, 32'h700, 32'h0);
    tick();
    chk_ctl("b2b_gap", 1'b0);
    chk("b2b_gap_pc", bus.redirect_pc, 32'h600);
    tick();
    chk_ctl("b2b2", 1'b1);
    chk("b2b2_pc", bus.redirect_pc, 32'h700);
    chk("b2b_taken", {16'd0, bus.cnt_taken}, 32'd3);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();

    // Not-taken conditional, then illegal decision
    drive(1'b1, 1'b1, 2'b00, 32'hA00, 32'h0);
    tick();
    chk_ctl("nt", 1'b0);
    chk("nt_cond", {16'd0, bus.cnt_cond}, 32'd1);
    drive(1'b1, 1'b0, 2'b11, 32'hB00, 32'hC00);
    tick();
    chk_ctl("ill", 1'b0);
    chk("ill_taken", {16'd0, bus.cnt_taken}, 32'd3);
    chk("ill_pc", bus.redirect_pc, 32'h700);

    // Reset during REDIRECT drops the target
    drive(1'b1, 1'b0, 2'b01, 32'h800, 32'h0);
    tick();
    chk_ctl("rr_pre", 1'b1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    chk_ctl("rr", 1'b0);
    chk("rr_pc", bus.redirect_pc, 32'h0);
    chk("rr_taken", {16'd0, bus.cnt_taken}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_ctl("rr_rel", 1'b0);

    // Saturation of the hold counter
    drive(1'b1, 1'b0, 2'b01, 32'h900, 32'h0);
    bus.fetch_ready = 1'b0;
    tick();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (65534) tick();
    chk("sat_fffe", {16'd0, bus.cnt_hold}, 32'hFFFE);
    tick();
    chk("sat_ffff", {16'd0, bus.cnt_hold}, 32'hFFFF);
    tick();
    chk("sat_hold", {16'd0, bus.cnt_hold}, 32'hFFFF);
    chk_ctl("sat_ctl", 1'b1);
    bus.fetch_ready = 1'b1;
    tick();
    chk_ctl("sat_exit", 1'b0);
    chk("sat_taken", {16'd0, bus.cnt_taken}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
